// File: rtl/axi_regfile_gen.sv
// AXI4-Lite slave register file with per-register read-only and self-clearing
// pulse modes, plus write/read strobes for attached logic.
module axi_regfile_gen #(
  parameter int unsigned         NUM_REGS   = 16,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0] PULSE_MASK = '0
) (
  input  logic                           axi_aclk,
  input  logic                           axi_areset,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [2:0]                     s_axi_awprot,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [2:0]                     s_axi_arprot,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] slv_reg,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] slv_read,
  output logic [NUM_REGS-1:0]            wr_stb,
  output logic [NUM_REGS-1:0]            rd_stb
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int unsigned REG_W  = NUM_REGS * DATA_WIDTH;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Registered state
  logic                  r_awready, r_wready, r_arready;
  logic                  r_aw_held, r_w_held;
  logic [IDX_W-1:0]      r_aw_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [REG_W-1:0]      r_slv_reg;
  logic [NUM_REGS-1:0]   r_wr_stb, r_rd_stb;

  // Next-state values
  logic                  w_awready_nxt, w_wready_nxt, w_arready_nxt;
  logic                  w_aw_held_nxt, w_w_held_nxt;
  logic [IDX_W-1:0]      w_aw_idx_nxt;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic [STRB_W-1:0]     w_wstrb_nxt;
  logic                  w_bvalid_nxt;
  logic [1:0]            w_bresp_nxt;
  logic                  w_rvalid_nxt;
  logic [1:0]            w_rresp_nxt;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic [REG_W-1:0]      w_slv_reg_nxt;
  logic [NUM_REGS-1:0]   w_wr_stb_nxt, w_rd_stb_nxt;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_wr_ok;

  // Handshakes and the effective write operands (held copy or live bus)
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_wr_fire;
  logic [IDX_W-1:0]      w_wr_idx, w_ar_idx;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic                  w_unused;

  assign w_aw_hs   = s_axi_awvalid && r_awready;
  assign w_w_hs    = s_axi_wvalid && r_wready;
  assign w_ar_hs   = s_axi_arvalid && r_arready;
  assign w_wr_fire = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_idx  = r_aw_held ? r_aw_idx : s_axi_awaddr[ADDR_WIDTH-1:OFF_W];
  assign w_wr_data = r_w_held ? r_wdata : s_axi_wdata;
  assign w_wr_strb = r_w_held ? r_wstrb : s_axi_wstrb;
  assign w_ar_idx  = s_axi_araddr[ADDR_WIDTH-1:OFF_W];

  // Protection bits, byte-offset bits and RW read-back inputs carry no meaning
  assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[OFF_W-1:0],
                      s_axi_araddr[OFF_W-1:0], slv_read};

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_arready = r_arready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign slv_reg       = r_slv_reg;
  assign wr_stb        = r_wr_stb;
  assign rd_stb        = r_rd_stb;

  // Next-state logic for register array, write channel and read channel
  always_comb begin
    w_slv_reg_nxt = r_slv_reg;
    w_wr_stb_nxt  = '0;
    w_rd_stb_nxt  = '0;
    w_wr_ok       = 1'b0;
    w_word        = '0;
    w_aw_held_nxt = r_aw_held;
    w_w_held_nxt  = r_w_held;
    w_aw_idx_nxt  = r_aw_idx;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_rvalid_nxt  = r_rvalid;
    w_rresp_nxt   = r_rresp;
    w_rdata_nxt   = r_rdata;

    // Pulse registers fall back to zero every cycle; a write merges enabled lanes
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      w_word = PULSE_MASK[i] ? '0 : r_slv_reg[i*DATA_WIDTH +: DATA_WIDTH];
      if (w_wr_fire && !RO_MASK[i] && (w_wr_idx == IDX_W'(i))) begin
        w_wr_ok         = 1'b1;
        w_wr_stb_nxt[i] = 1'b1;
        for (int j = 0; j < int'(STRB_W); j++) begin
          if (w_wr_strb[j]) w_word[j*8 +: 8] = w_wr_data[j*8 +: 8];
        end
      end
      w_slv_reg_nxt[i*DATA_WIDTH +: DATA_WIDTH] = w_word;
    end

    // AW and W are captured independently; the write fires once both are present
    if (w_wr_fire) begin
      w_aw_held_nxt = 1'b0;
      w_w_held_nxt  = 1'b0;
      w_bvalid_nxt  = 1'b1;
      w_bresp_nxt   = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (w_aw_hs) begin
        w_aw_held_nxt = 1'b1;
        w_aw_idx_nxt  = s_axi_awaddr[ADDR_WIDTH-1:OFF_W];
      end
      if (w_w_hs) begin
        w_w_held_nxt = 1'b1;
        w_wdata_nxt  = s_axi_wdata;
        w_wstrb_nxt  = s_axi_wstrb;
      end
      if (r_bvalid && s_axi_bready) w_bvalid_nxt = 1'b0;
    end

    // Read data is sampled in the AR handshake cycle and held until R completes
    if (r_rvalid && s_axi_rready) w_rvalid_nxt = 1'b0;
    if (w_ar_hs) begin
      w_rvalid_nxt = 1'b1;
      w_rdata_nxt  = '0;
      w_rresp_nxt  = RESP_SLVERR;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (w_ar_idx == IDX_W'(i)) begin
          w_rdata_nxt     = RO_MASK[i] ? slv_read[i*DATA_WIDTH +: DATA_WIDTH]
                                       : r_slv_reg[i*DATA_WIDTH +: DATA_WIDTH];
          w_rresp_nxt     = RESP_OKAY;
          w_rd_stb_nxt[i] = 1'b1;
        end
      end
    end

    w_awready_nxt = !w_aw_held_nxt && !w_bvalid_nxt;
    w_wready_nxt  = !w_w_held_nxt && !w_bvalid_nxt;
    w_arready_nxt = !w_rvalid_nxt;
  end

  // State registers with synchronous reset
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_arready <= 1'b1;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_slv_reg <= '0;
      r_wr_stb  <= '0;
      r_rd_stb  <= '0;
    end else begin
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_arready <= w_arready_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_aw_idx  <= w_aw_idx_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rresp   <= w_rresp_nxt;
      r_rdata   <= w_rdata_nxt;
      r_slv_reg <= w_slv_reg_nxt;
      r_wr_stb  <= w_wr_stb_nxt;
      r_rd_stb  <= w_rd_stb_nxt;
    end
  end

endmodule

// File: tb/tb_axi_regfile_gen.sv
// Directed bench for axi_regfile_gen: 12 registers, reg 0 read-only, reg 3 pulse.
module tb_axi_regfile_gen;

  localparam int unsigned NR = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned TW = NR * DW;

  logic          clk = 1'b0;
  logic          axi_areset;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [TW-1:0] slv_reg, slv_read;
  logic [NR-1:0] wr_stb, rd_stb;

  always #5 clk = ~clk;

  axi_regfile_gen #(
    .NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .RO_MASK(12'h001), .PULSE_MASK(12'h008)
  ) dut (
    .axi_aclk(clk), .axi_areset(axi_areset),
    .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .slv_reg(slv_reg), .slv_read(slv_read), .wr_stb(wr_stb), .rd_stb(rd_stb)
  );

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_val;
    logic [11:0] exp_stb;
  } vec_t;

  vec_t          vecs[16];
  int            n_chk = 0;
  int            n_fail = 0;
  logic [TW-1:0] exp_regs;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name);
    n_chk++;
    if (slv_reg !== exp_regs) begin
      n_fail++;
      $display("FAIL %s: slv_reg got %h expected %h", name, slv_reg, exp_regs);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, " bvalid"}, 64'(bvalid), 64'(0));
    chk({name, " rvalid"}, 64'(rvalid), 64'(0));
    chk({name, " bresp"}, 64'(bresp), 64'(0));
    chk({name, " rresp"}, 64'(rresp), 64'(0));
    chk({name, " rdata"}, 64'(rdata), 64'(0));
    chk({name, " awready"}, 64'(awready), 64'(1));
    chk({name, " wready"}, 64'(wready), 64'(1));
    chk({name, " arready"}, 64'(arready), 64'(1));
    chk({name, " wr_stb"}, 64'(wr_stb), 64'(0));
    chk({name, " rd_stb"}, 64'(rd_stb), 64'(0));
    chk_regs(name);
  endtask

  initial begin
    int idx;
    string nm;
    logic [31:0] held;

    axi_areset = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    bready = 1'b1; rready = 1'b1;
    slv_read = {NR{32'h5555AAAA}};
    slv_read[31:0] = 32'hDEADBEEF;
    exp_regs = '0;

    //            wr    addr   data          strb   resp   exp_val       exp_stb
    vecs[0]  = '{1'b1, 8'h08, 32'hA5A50003, 4'hF, 2'b00, 32'hA5A50003, 12'h004};
    vecs[1]  = '{1'b0, 8'h08, 32'h0,        4'h0, 2'b00, 32'hA5A50003, 12'h004};
    vecs[2]  = '{1'b1, 8'h14, 32'h11223344, 4'hF, 2'b00, 32'h11223344, 12'h020};
    vecs[3]  = '{1'b1, 8'h00, 32'h12345678, 4'hF, 2'b10, 32'h0,        12'h000};
    vecs[4]  = '{1'b0, 8'h00, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 12'h001};
    vecs[5]  = '{1'b1, 8'h30, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,        12'h000};
    vecs[6]  = '{1'b0, 8'h30, 32'h0,        4'h0, 2'b10, 32'h0,        12'h000};
    vecs[7]  = '{1'b1, 8'h0C, 32'h00000001, 4'hF, 2'b00, 32'h00000001, 12'h008};
    vecs[8]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'h0,        12'h008};
    vecs[9]  = '{1'b1, 8'h1F, 32'hCAFEF00D, 4'h9, 2'b00, 32'hCA00000D, 12'h080};
    vecs[10] = '{1'b0, 8'h1D, 32'h0,        4'h0, 2'b00, 32'hCA00000D, 12'h080};
    vecs[11] = '{1'b1, 8'hFC, 32'h01010101, 4'hF, 2'b10, 32'h0,        12'h000};
    vecs[12] = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h0,        12'h002};
    vecs[13] = '{1'b1, 8'h2C, 32'hFFFFFFFF, 4'h4, 2'b00, 32'h00FF0000, 12'h800};
    vecs[14] = '{1'b0, 8'h2C, 32'h0,        4'h0, 2'b00, 32'h00FF0000, 12'h800};
    vecs[15] = '{1'b1, 8'h0C, 32'h80000001, 4'hF, 2'b00, 32'h80000001, 12'h008};

    tick();
    tick();
    axi_areset = 1'b0;
    chk_idle("reset");

    // Table-driven single transactions (AW and W in the same cycle)
    for (int k = 0; k < 16; k++) begin
      idx = int'(vecs[k].addr[7:2]);
      nm = $sformatf("v%0d", k);
      if (vecs[k].is_wr) begin
        awaddr = vecs[k].addr; wdata = vecs[k].data; wstrb = vecs[k].strb;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        if (vecs[k].exp_resp == 2'b00) exp_regs[idx*DW +: DW] = vecs[k].exp_val;
        chk({nm, " bvalid"}, 64'(bvalid), 64'(1));
        chk({nm, " bresp"}, 64'(bresp), 64'(vecs[k].exp_resp));
        chk({nm, " wr_stb"}, 64'(wr_stb), 64'(vecs[k].exp_stb));
        chk({nm, " awready"}, 64'(awready), 64'(0));
        chk_regs({nm, " regs"});
        tick();
        if (idx == 3) exp_regs[3*DW +: DW] = '0;
        chk({nm, " bvalid done"}, 64'(bvalid), 64'(0));
        chk({nm, " wr_stb done"}, 64'(wr_stb), 64'(0));
        chk_regs({nm, " regs after"});
      end else begin
        araddr = vecs[k].addr;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk({nm, " rvalid"}, 64'(rvalid), 64'(1));
        chk({nm, " rdata"}, 64'(rdata), 64'(vecs[k].exp_val));
        chk({nm, " rresp"}, 64'(rresp), 64'(vecs[k].exp_resp));
        chk({nm, " rd_stb"}, 64'(rd_stb), 64'(vecs[k].exp_stb));
        chk({nm, " arready"}, 64'(arready), 64'(0));
        tick();
        chk({nm, " rvalid done"}, 64'(rvalid), 64'(0));
        chk({nm, " rd_stb done"}, 64'(rd_stb), 64'(0));
      end
    end

    // W arrives three cycles before AW; only byte lane 1 of reg 5 changes
    awaddr = 8'h14; wdata = 32'h0000BB00; wstrb = 4'h2;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("wfirst wready", 64'(wready), 64'(0));
      chk("wfirst awready", 64'(awready), 64'(1));
      chk("wfirst bvalid", 64'(bvalid), 64'(0));
      if (c == 2) awvalid = 1'b1;
      tick();
    end
    awvalid = 1'b0;
    exp_regs[5*DW +: DW] = 32'h1122BB44;
    chk("wfirst bvalid", 64'(bvalid), 64'(1));
    chk("wfirst wr_stb", 64'(wr_stb), 64'(12'h020));
    chk_regs("wfirst regs");
    tick();

    // AW arrives before W for reg 6, only byte lane 0 enabled
    awaddr = 8'h18; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("awfirst awready", 64'(awready), 64'(0));
    chk("awfirst bvalid", 64'(bvalid), 64'(0));
    wdata = 32'h12345677; wstrb = 4'h1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    exp_regs[6*DW +: DW] = 32'h00000077;
    chk("awfirst bvalid", 64'(bvalid), 64'(1));
    chk_regs("awfirst regs");
    tick();

    // Read and write of reg 2 in the same cycle: read returns the old value
    awaddr = 8'h08; wdata = 32'h0BADF00D; wstrb = 4'hF; araddr = 8'h08;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp_regs[2*DW +: DW] = 32'h0BADF00D;
    chk("rw rdata", 64'(rdata), 64'(32'hA5A50003));
    chk("rw rd_stb", 64'(rd_stb), 64'(12'h004));
    chk("rw wr_stb", 64'(wr_stb), 64'(12'h004));
    chk_regs("rw regs");
    tick();

    // Stall both response channels, then reset in the middle of the stall
    bready = 1'b0; rready = 1'b0;
    awaddr = 8'h24; wdata = 32'h99887766; wstrb = 4'hF; araddr = 8'h08;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    exp_regs[9*DW +: DW] = 32'h99887766;
    held = 32'h0BADF00D;
    for (int c = 0; c < 5; c++) begin
      chk("stall bvalid", 64'(bvalid), 64'(1));
      chk("stall rvalid", 64'(rvalid), 64'(1));
      chk("stall bresp", 64'(bresp), 64'(0));
      chk("stall rdata", 64'(rdata), 64'(held));
      chk("stall rresp", 64'(rresp), 64'(0));
      chk("stall readies", 64'({awready, wready, arready}), 64'(0));
      chk_regs("stall regs");
      tick();
    end
    arvalid = 1'b0;
    axi_areset = 1'b1;
    tick();
    axi_areset = 1'b0;
    exp_regs = '0;
    chk_idle("midreset");
    bready = 1'b1; rready = 1'b1;
    tick();
    chk_idle("postreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_regfile_gen.md
Name: axi_regfile_gen

Overview:
Parametrised AXI4-Lite slave register file; the next generation of the fixed 16x32 register file used for software control of the unit under test.
- Generalised in register count and data width.
- Per-register read-only and self-clearing pulse modes.
- Per-register write/read strobes for attached logic.
- SLVERR on illegal accesses.
- Sits directly on an interconnect master port in the top level.

Parameters:
NUM_REGS, 16, number of registers (1..256, need not be a power of 2)
DATA_WIDTH, 32, register/bus width (32 or 64)
ADDR_WIDTH, 8, AXI address width; must satisfy NUM_REGS*DATA_WIDTH/8 <= 2**ADDR_WIDTH
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only (reads slv_read, writes rejected)
PULSE_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i self-clearing (written bits high for exactly one cycle)

Ports:
axi_aclk  in  1  clock
axi_areset  in  1  reset; one clock, synchronous, active-high
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid/s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wvalid/s_axi_wready  in/out  1  W handshake
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid/s_axi_bready  out/in  1  B handshake
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid/s_axi_arready  in/out  1  AR handshake
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid/s_axi_rready  out/in  1  R handshake
slv_reg  out  NUM_REGS*DATA_WIDTH  register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
slv_read  in  NUM_REGS*DATA_WIDTH  read-back values for RO registers (ignored for RW)
wr_stb  out  NUM_REGS  one-cycle pulse when register i is successfully written
rd_stb  out  NUM_REGS  one-cycle pulse when register i is read (for pop-on-read logic)

Behaviour:
- Reset: all slv_reg=0; wr_stb, rd_stb=0; bvalid, rvalid=0; bresp, rresp=00; rdata=0; awready=wready=arready=1; captured AW/W flags cleared. Reset mid-transaction abandons it with no register update.
- Decode: index = addr >> log2(DATA_WIDTH/8). Low byte-offset bits ignored.
- Write channel:
  - AW and W are captured independently, in either order or the same cycle.
  - awready is high only while no AW is held and bvalid=0; wready likewise for W.
  - Write executes on the edge after both are held (cycle T = cycle the later handshake completes). At edge T+1: register updated, bvalid=1, wr_stb[i]=1 for cycle T+1 only, both holds cleared.
  - Byte lane j is updated only if wstrb[j]=1.
  - index >= NUM_REGS, or RO_MASK[i]=1: no update, no wr_stb, bresp=SLVERR.
  - bvalid held until bready; new AW/W accepted the cycle after the B handshake.
- Pulse registers: after a write, bits stay set for exactly cycle T+1, then clear to 0. A back-to-back write re-pulses.
- Read channel:
  - arready = !rvalid.
  - AR handshake at cycle T gives, at edge T+1: rvalid=1 and rdata = slv_read[i] if RO_MASK[i], else slv_reg[i], as sampled in cycle T. rd_stb[i] is high for cycle T+1.
  - Out-of-range index: rdata=0, rresp=SLVERR, no rd_stb.
  - rdata/rresp stable while rvalid && !rready.
- Simultaneous read and write of the same register: channels are independent. The read returns the pre-write value if its AR handshake is in or before cycle T.
- Throughput: one write per 2 cycles minimum with bready tied high. One read per 2 cycles.

Test Plan:
- Reset, then write 0xA5A5_0003 to reg 2 with AW and W in the same cycle, wstrb=F -> bvalid the next cycle, bresp=00, slv_reg[2]=0xA5A5_0003, wr_stb[2] pulses once; read reg 2 returns the same value with rresp=00.
- W presented 3 cycles before AW, wstrb=0x2, data 0x0000_BB00 to reg 5 (previously 0x11223344) -> reg 5 = 0x1122BB44, bvalid one cycle after AW accepted.
- RO_MASK bit 0 set, slv_read[0]=0xDEADBEEF: write reg 0 -> SLVERR, no wr_stb; read reg 0 -> 0xDEADBEEF, OKAY, rd_stb[0] pulses.
- NUM_REGS=12: read/write address 0x30 -> SLVERR, rdata=0, no strobes, no register changes.
- PULSE_MASK bit 3 set: write 0x1 -> slv_reg[3]=1 for exactly one cycle, then 0; read returns 0.
- bready/rready held low 5 cycles -> bvalid/rvalid and data stable, awready/wready/arready low; assert axi_areset mid-stall -> all outputs return to reset values on the next edge, registers cleared.
